// File: rtl/date_stream_parser.sv
// rtl/date_stream_parser.sv - streaming ASCII date recogniser (Y..Y<SEP>MM<SEP>DD)
// Emits a one-cycle result or err pulse per well-formed date and captures BCD fields.
module date_stream_parser #(
  parameter int          YEAR_DIGITS = 4,
  parameter logic [7:0]  SEP         = 8'h2D,
  parameter int          CHECK_MODE  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               char,
  input  logic                     valid,
  output logic                     result,
  output logic                     err,
  output logic [4*YEAR_DIGITS-1:0] year,
  output logic [7:0]               month,
  output logic [7:0]               day
);

  localparam int YW = 4 * YEAR_DIGITS;

  typedef enum logic [2:0] {
    ST_Y, ST_S1, ST_M1, ST_M2, ST_S2, ST_D1, ST_D2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [YW-1:0] ybuf_q, ybuf_d;
  logic [7:0]    mbuf_q, mbuf_d;
  logic [3:0]    dhi_q, dhi_d;
  logic          result_q, result_d;
  logic          err_q, err_d;
  logic [YW-1:0] year_q, year_d;
  logic [7:0]    month_q, month_d;
  logic [7:0]    day_q, day_d;

  logic          is_digit, is_sep, mismatch;
  logic [3:0]    dig;
  logic [7:0]    day_cand;
  logic [15:0]   year_ext;
  logic          leap, basic_ok, date_ok;
  logic [7:0]    max_day;

  assign is_digit = (char >= 8'h30) && (char <= 8'h39);
  assign is_sep   = (char == SEP);
  assign dig      = char[3:0];
  assign day_cand = {dhi_q, dig};
  assign year_ext = 16'(ybuf_q);

  // Divisibility by 4 of a two-digit BCD number: odd tens need units 2/6, even tens 0/4/8.
  function automatic logic div4(input logic [3:0] tens, input logic [3:0] units);
    if (tens[0]) return (units == 4'd2) || (units == 4'd6);
    else         return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
  endfunction

  always_comb begin
    leap = div4(year_ext[7:4], year_ext[3:0]);
    if (year_ext[7:0] == 8'h00) begin
      if (YEAR_DIGITS == 4) leap = div4(year_ext[15:12], year_ext[11:8]);
      else                  leap = 1'b1;
    end
  end

  always_comb begin
    max_day = 8'h31;
    case (mbuf_q)
      8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
      8'h02:                      max_day = leap ? 8'h29 : 8'h28;
      default:                    max_day = 8'h31;
    endcase
  end

  // Fields are valid BCD here, so hex magnitude compares order them correctly.
  assign basic_ok = (mbuf_q != 8'h00) && (mbuf_q <= 8'h12) &&
                    (day_cand != 8'h00) && (day_cand <= 8'h31);

  always_comb begin
    if (CHECK_MODE == 0)      date_ok = 1'b1;
    else if (CHECK_MODE == 1) date_ok = basic_ok;
    else                      date_ok = basic_ok && (day_cand <= max_day);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ybuf_d   = ybuf_q;
    mbuf_d   = mbuf_q;
    dhi_d    = dhi_q;
    result_d = 1'b0;
    err_d    = 1'b0;
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    mismatch = 1'b0;

    if (valid) begin
      case (state_q)
        ST_Y: begin
          if (is_digit) begin
            ybuf_d = {ybuf_q[YW-5:0], dig};
            if (cnt_q == 2'(YEAR_DIGITS - 1)) begin
              state_d = ST_S1;
              cnt_d   = 2'd0;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end else begin
            mismatch = 1'b1;
          end
        end
        ST_S1: if (is_sep) state_d = ST_M1; else mismatch = 1'b1;
        ST_M1, ST_M2: begin
          if (is_digit) begin
            mbuf_d  = {mbuf_q[3:0], dig};
            state_d = (state_q == ST_M1) ? ST_M2 : ST_S2;
          end else begin
            mismatch = 1'b1;
          end
        end
        ST_S2: if (is_sep) state_d = ST_D1; else mismatch = 1'b1;
        ST_D1: begin
          if (is_digit) begin
            dhi_d   = dig;
            state_d = ST_D2;
          end else begin
            mismatch = 1'b1;
          end
        end
        ST_D2: begin
          if (is_digit) begin
            state_d = ST_Y;
            cnt_d   = 2'd0;
            if (date_ok) begin
              result_d = 1'b1;
              year_d   = ybuf_q;
              month_d  = mbuf_q;
              day_d    = day_cand;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            mismatch = 1'b1;
          end
        end
        default: mismatch = 1'b1;
      endcase

      // A stray digit may be the first digit of a new year.
      if (mismatch) begin
        state_d = ST_Y;
        if (is_digit) begin
          cnt_d  = 2'd1;
          ybuf_d = {ybuf_q[YW-5:0], dig};
        end else begin
          cnt_d = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_Y;
      cnt_q    <= 2'd0;
      ybuf_q   <= '0;
      mbuf_q   <= 8'h00;
      dhi_q    <= 4'h0;
      result_q <= 1'b0;
      err_q    <= 1'b0;
      year_q   <= '0;
      month_q  <= 8'h00;
      day_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ybuf_q   <= ybuf_d;
      mbuf_q   <= mbuf_d;
      dhi_q    <= dhi_d;
      result_q <= result_d;
      err_q    <= err_d;
      year_q   <= year_d;
      month_q  <= month_d;
      day_q    <= day_d;
    end
  end

  assign result = result_q;
  assign err    = err_q;
  assign year   = year_q;
  assign month  = month_q;
  assign day    = day_q;

endmodule
